// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive FSM encoding, byte-phase type and oversampling constants.
package uart_pkg;
    localparam int OVERSAMPLE  = 16;
    localparam int MID_TICK    = 7;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic {PH_HIGH, PH_LOW} phase_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x-oversampled 8N1 byte receiver with done/error pulses.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            done,
    output logic            frame_err,
    output logic            parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DBIT);
    localparam logic [TW-1:0] T_MID  = TW'(MID_TICK);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

    rx_state_t       state;
    logic [1:0]      sync;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            rx_s;
    logic            par_ok;

    assign rx_s = sync[1];

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = ~^{shreg, par_bit};
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sync      <= 2'b11;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync      <= {sync[0], rx};
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: if (!rx_s) begin
                    state    <= START;
                    tick_cnt <= '0;
                end
                START: if (s_tick) begin
                    if (tick_cnt == T_MID) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (tick_cnt == T_LAST) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        shreg    <= {rx_s, shreg[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == B_LAST) state <= PARITY;
`else
                        if (bit_cnt == B_LAST) state <= STOP;
`endif
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (s_tick) begin
                    if (tick_cnt == T_LAST) begin
                        tick_cnt <= '0;
                        par_bit  <= rx_s;
                        state    <= STOP;
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
`endif
                STOP: if (s_tick) begin
                    if (tick_cnt == T_STOP) begin
                        tick_cnt  <= '0;
                        state     <= IDLE;
                        dout      <= shreg;
                        done      <= rx_s && par_ok;
                        frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= !par_ok;
`endif
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: pairs received bytes into words (first byte high) with valid/ack hand-off and sticky overrun.
// Parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int WORD_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic              rx,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_word_valid,
    input  logic              rx_word_ack,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    logic [DBIT-1:0] byte_data;
    logic [DBIT-1:0] hi;
    logic            byte_done;
    logic            word_done;
    phase_t          phase;

    uart_rx_byte #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_byte (
        .clk        (clk),
        .reset      (reset),
        .s_tick     (s_tick),
        .rx         (rx),
        .dout       (byte_data),
        .done       (byte_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    assign word_done = byte_done && phase == PH_LOW;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase         <= PH_HIGH;
            hi            <= '0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (byte_done) begin
                phase <= phase == PH_HIGH ? PH_LOW : PH_HIGH;
                if (phase == PH_HIGH) hi <= byte_data;
            end
            // a bad frame drops any half-built word so pairing realigns
            if (frame_err || parity_err) phase <= PH_HIGH;
            if (rx_word_valid && rx_word_ack) begin
                rx_word_valid <= 1'b0;
                overrun       <= 1'b0;
            end
            if (word_done) begin
                if (!rx_word_valid || rx_word_ack) begin
                    rx_word       <= WORD_W'({hi, byte_data});
                    rx_word_valid <= 1'b1;
                end else
                    overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: randomized scoreboard bench for uart_rx_word; parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx_word;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_tick = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] rx_word;
    logic        rx_word_valid;
    logic        rx_word_ack = 1'b0;
    logic        frame_err, parity_err, overrun;

    int total = 0, bad = 0;
    int fe_cnt = 0, pe_cnt = 0, exp_fe = 0;
    int tdiv = 0, wn = 0;
    logic [15:0] exp_q[$];
    logic        pv = 1'b0;
    logic [15:0] pw = '0;

    uart_rx_word dut (
        .clk           (clk),
        .reset         (reset),
        .s_tick        (s_tick),
        .rx            (rx),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .rx_word_ack   (rx_word_ack),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // tick every 4 clks keeps the run short; the receiver only counts ticks
    always @(posedge clk) begin
        tdiv   <= tdiv == 3 ? 0 : tdiv + 1;
        s_tick <= tdiv == 3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (rx_word_valid && (!pv || rx_word != pw)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", rx_word);
            end else
                chk("word", {16'h0, rx_word}, {16'h0, exp_q.pop_front()});
        end
        pv = rx_word_valid;
        pw = rx_word;
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
    endtask

    task automatic bit_out(input logic v, input int n);
        #1 rx = v;
        tick_wait(n);
    endtask

    // bad stop bit is shortened so the line is high again before a false start could be confirmed
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        bit_out(1'b0, 16);
        for (int i = 0; i < 8; i++) bit_out(d[i], 16);
`ifdef UART_RX_PARITY_EN
        bit_out(^d ^ par_flip, 16);
`endif
        bit_out(stop, stop ? 16 : 12);
        bit_out(1'b1, stop ? 2 : 6);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_frame(w[15:8], 1'b1, 1'b0);
        send_frame(w[7:0], 1'b1, 1'b0);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_word_ack = 1'b1;
        @(negedge clk);
        rx_word_ack = 1'b0;
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fd[$];
        bit         fg[$];
        logic [7:0] h;
        bit         hv;
        repeat (5) @(negedge clk);
        chk("rst_word", {16'h0, rx_word}, 32'h0);
        chk("rst_valid", rx_word_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b1;
        tick_wait(4);

        exp_q.push_back(16'hABCD);
        send_word(16'hABCD);
        chk("abcd_valid", rx_word_valid, 1);
        chk("abcd_ferr_cnt", fe_cnt, 0);
        chk("abcd_ovr", overrun, 0);
        ack_pulse();
        @(negedge clk);
        chk("abcd_ack_valid", rx_word_valid, 0);

        bit_out(1'b0, 3);
        bit_out(1'b1, 12);
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        chk("glitch_valid", rx_word_valid, 1);
        ack_pulse();

        send_frame(8'h55, 1'b0, 1'b0);
        exp_fe++;
        exp_q.push_back(16'h6677);
        send_word(16'h6677);
        chk("ferr_cnt", fe_cnt, exp_fe);
        chk("ferr_word", {16'h0, rx_word}, 32'h6677);
        ack_pulse();

        exp_q.push_back(16'h1111);
        send_word(16'h1111);
        send_word(16'h2222);
        chk("ovr_word", {16'h0, rx_word}, 32'h1111);
        chk("ovr_set", overrun, 1);
        chk("ovr_valid", rx_word_valid, 1);
        ack_pulse();
        @(negedge clk);
        chk("ovr_ack_valid", rx_word_valid, 0);
        chk("ovr_ack_clear", overrun, 0);

        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        send_word(16'h3333);
        fork
            send_word(16'h4444);
            begin
                wn = 0;
                @(negedge clk);
                while (!dut.word_done && wn < 5000) begin
                    @(negedge clk);
                    wn++;
                end
                chk("sameclk_window", wn < 5000, 1);
                rx_word_ack = 1'b1;
                @(negedge clk);
                rx_word_ack = 1'b0;
            end
        join
        chk("sameclk_word", {16'h0, rx_word}, 32'h4444);
        chk("sameclk_valid", rx_word_valid, 1);
        chk("sameclk_ovr", overrun, 0);
        ack_pulse();

        send_frame(8'hBE, 1'b1, 1'b0);
        bit_out(1'b0, 16);
        for (int i = 0; i < 3; i++) bit_out(1'b1, 16);
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_word", {16'h0, rx_word}, 32'h0);
        chk("midrst_valid", rx_word_valid, 0);
        chk("midrst_ovr", overrun, 0);
        reset = 1'b1;
        tick_wait(20);
        exp_q.push_back(16'h0102);
        send_word(16'h0102);
        chk("midrst_after_valid", rx_word_valid, 1);
        ack_pulse();

        // reference model: pair good bytes in order, a bad frame discards a held byte
        for (int it = 0; it < 8; it++) begin
            int sel;
            fd.delete();
            fg.delete();
            sel = $urandom_range(0, 2);
            if (sel == 2) begin
                fd.push_back(8'($urandom));
                fg.push_back(1'b1);
            end
            if (sel != 0) begin
                fd.push_back(8'($urandom));
                fg.push_back(1'b0);
            end
            fd.push_back(8'($urandom));
            fg.push_back(1'b1);
            fd.push_back(8'($urandom));
            fg.push_back(1'b1);
            hv = 1'b0;
            h = '0;
            foreach (fd[k]) begin
                if (!fg[k]) begin
                    hv = 1'b0;
                    exp_fe++;
                end else if (!hv) begin
                    h = fd[k];
                    hv = 1'b1;
                end else begin
                    exp_q.push_back({h, fd[k]});
                    hv = 1'b0;
                end
            end
            foreach (fd[k]) send_frame(fd[k], fg[k], 1'b0);
            chk("rand_valid", rx_word_valid, 1);
            ack_pulse();
            @(negedge clk);
            chk("rand_ack_valid", rx_word_valid, 0);
        end
        chk("rand_ferr_cnt", fe_cnt, exp_fe);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_err_cnt", pe_cnt, 1);
        exp_q.push_back(16'h0809);
        send_word(16'h0809);
        chk("par_realign_valid", rx_word_valid, 1);
        ack_pulse();
`else
        chk("par_err_tied0", pe_cnt, 0);
`endif
        tick_wait(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
